// File: rtl/array_west_driver_if.sv
// L0 show-ahead FIFO read port as seen by the west-edge driver.
// The master side pops the head vector and the slave side presents it.
interface array_west_driver_if #(
    parameter int row = 8,
    parameter int bw  = 4
);
    logic [row*bw-1:0] l0_out;
    logic              l0_empty;
    logic              l0_rd;

    modport master (input l0_out, input l0_empty, output l0_rd);
    modport slave  (output l0_out, output l0_empty, input l0_rd);
endinterface

// File: rtl/array_west_driver.sv
// West-edge transmitter for the mac_array: sequences one WS or OS pass out of the L0 FIFO
// and drives each row's inst_w/in_w with a diagonal skew of one cycle per row.
module array_west_driver #(
    parameter int row = 8,
    parameter int col = 8,
    parameter int bw  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [15:0]         k_len,
    array_west_driver_if.master l0,
    output logic [row*bw-1:0]   array_in_w,
    output logic [row*3-1:0]    array_inst_w,
    output logic                busy,
    output logic                done
);
    localparam logic [2:0] WS_LOAD = 3'b101;
    localparam logic [2:0] WS_EXEC = 3'b110;
    localparam logic [2:0] WS_IDLE = 3'b100;
    localparam logic [2:0] OS_EXEC = 3'b010;
    localparam logic [2:0] OS_MOVE = 3'b001;
    localparam logic [2:0] OS_IDLE = 3'b000;

    localparam logic [15:0] LOAD_LAST  = 16'(col - 1);
    localparam logic [15:0] DRAIN_OS_L = 16'(2 * row - 1);
    localparam logic [15:0] DRAIN_WS_L = 16'(row + col - 2);

    typedef enum logic [2:0] {S_IDLE, S_LOADW, S_GAP, S_EXEC, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [15:0]       klen_q, klen_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              pop;
    logic [2:0]        idle_code;
    logic [2:0]        inst0_d;
    logic [row*bw-1:0] data0_d;
    logic [2:0]        inst_q [row];

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        klen_d    = klen_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        idle_code = mode_q ? WS_IDLE : OS_IDLE;
        inst0_d   = idle_code;
        data0_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    klen_d  = k_len;
                    cnt_d   = '0;
                    state_d = mode ? S_LOADW : ((k_len == 16'd0) ? S_DRAIN : S_EXEC);
                end
            end
            S_LOADW: begin
                pop = !l0.l0_empty;
                if (pop) begin
                    inst0_d = WS_LOAD;
                    data0_d = l0.l0_out;
                    if (cnt_q == LOAD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_GAP: begin
                inst0_d = WS_IDLE;
                state_d = (klen_q == 16'd0) ? S_DRAIN : S_EXEC;
            end
            S_EXEC: begin
                pop = !l0.l0_empty;
                if (pop) begin
                    inst0_d = mode_q ? WS_EXEC : OS_EXEC;
                    data0_d = l0.l0_out;
                    if (cnt_q == klen_q - 16'd1) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_DRAIN: begin
                // OS moves results out two cycles per hop; WS flushes the skewed psums south.
                inst0_d = mode_q ? WS_IDLE : OS_MOVE;
                if (cnt_q == (mode_q ? DRAIN_WS_L : DRAIN_OS_L)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign l0.l0_rd = pop;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            klen_q  <= '0;
            cnt_q   <= '0;
            for (int s = 0; s < row; s++) inst_q[s] <= 3'b000;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            klen_q    <= klen_d;
            cnt_q     <= cnt_d;
            inst_q[0] <= inst0_d;
            for (int s = 1; s < row; s++) inst_q[s] <= inst_q[s-1];
        end
    end

    // Lane r keeps only its own slice, delayed r cycles behind the row-0 stage.
    for (genvar r = 0; r < row; r++) begin : g_lane
        logic [bw-1:0] dq [r+1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i <= r; i++) dq[i] <= '0;
            end else begin
                dq[0] <= data0_d[r*bw +: bw];
                for (int i = 1; i <= r; i++) dq[i] <= dq[i-1];
            end
        end

        assign array_in_w[r*bw +: bw] = dq[r];
        assign array_inst_w[r*3 +: 3] = inst_q[r];
    end
endmodule

// File: tb/tb_array_west_driver.sv
// Directed bench for array_west_driver: per-cycle code/data schedules are written out by hand
// and every lane is compared against them with its diagonal skew applied.
module tb_array_west_driver;
    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int BW  = 4;
    localparam logic [2:0] WL = 3'b101, WE = 3'b110, WI = 3'b100;
    localparam logic [2:0] OE = 3'b010, OM = 3'b001, OI = 3'b000;

    logic              clk = 1'b0;
    logic              reset, start, mode;
    logic [15:0]       k_len;
    logic [ROW*BW-1:0] array_in_w;
    logic [ROW*3-1:0]  array_inst_w;
    logic              busy, done;

    array_west_driver_if #(.row(ROW), .bw(BW)) l0 ();

    array_west_driver #(.row(ROW), .col(COL), .bw(BW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .k_len(k_len),
        .l0(l0.master), .array_in_w(array_in_w), .array_inst_w(array_inst_w),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Show-ahead FIFO model: head vector p has lane r nibble = p+r+1.
    int   pidx;
    logic fifo_clr;
    function automatic logic [ROW*BW-1:0] vec_of(input int p);
        logic [ROW*BW-1:0] v;
        for (int r = 0; r < ROW; r++) v[r*BW +: BW] = BW'(p + r + 1);
        return v;
    endfunction
    always @(posedge clk) begin
        if (fifo_clr) pidx <= 0;
        else if (l0.l0_rd) pidx <= pidx + 1;
    end
    assign l0.l0_out = vec_of(pidx);

    // Expected row-0 schedule: ec[j] code in cycle j, ep[j] pop index or -1.
    logic [2:0] ec [64];
    int         ep [64];
    int         nj, np;

    task automatic plan_clear();
        nj = 0;
        np = 0;
    endtask

    task automatic add(input logic [2:0] c, input int n, input bit is_pop);
        for (int i = 0; i < n; i++) begin
            nj++;
            ec[nj] = c;
            ep[nj] = is_pop ? np : -1;
            if (is_pop) np++;
        end
    endtask

    logic [ROW*3-1:0]  rinst [64];
    logic [ROW*BW-1:0] rdat  [64];
    logic              rdone [64];
    logic              rbusy [64];
    logic              rrd   [64];
    logic              remp  [64];

    task automatic begin_pass(input logic m, input logic [15:0] k);
        @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr    = 1'b0;
        start       = 1'b1;
        mode        = m;
        k_len       = k;
        l0.l0_empty = 1'b0;
    endtask

    task automatic run(input int n, input int st_a, input int st_b, input int restart_at);
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            start       = (k == restart_at);
            l0.l0_empty = (k == st_a) || (k == st_b);
            #1;
            rinst[k] = array_inst_w;
            rdat[k]  = array_in_w;
            rdone[k] = done;
            rbusy[k] = busy;
            rrd[k]   = l0.l0_rd;
            remp[k]  = l0.l0_empty;
        end
        start = 1'b0;
    endtask

    task automatic check_plan(input string tag);
        int n;
        int pops;
        logic [BW-1:0] ed;
        n    = nj + ROW + 2;
        pops = 0;
        for (int r = 0; r < ROW; r++) begin
            for (int j = 1; j <= nj; j++) begin
                ed = (ep[j] < 0) ? '0 : BW'(ep[j] + r + 1);
                chk($sformatf("%s inst L%0d c%0d", tag, r, j), rinst[j+1+r][r*3 +: 3], ec[j]);
                chk($sformatf("%s data L%0d c%0d", tag, r, j), rdat[j+1+r][r*BW +: BW], ed);
            end
        end
        for (int k = 1; k < n; k++) begin
            chk($sformatf("%s done c%0d", tag, k), rdone[k], k == nj);
            chk($sformatf("%s busy c%0d", tag, k), rbusy[k], k < nj);
            if (rrd[k] && remp[k]) chk($sformatf("%s rd_when_empty c%0d", tag, k), 1, 0);
            if (rrd[k]) pops++;
        end
        chk($sformatf("%s pops", tag), pops, np);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        mode        = 1'b0;
        k_len       = '0;
        fifo_clr    = 1'b1;
        l0.l0_empty = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst inst", array_inst_w, 0);
        chk("rst data", array_in_w, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst rd", l0.l0_rd, 0);
        reset = 1'b0;

        // WS, k_len=4, FIFO never empty
        plan_clear();
        add(WL, COL, 1); add(WI, 1, 0); add(WE, 4, 1); add(WI, ROW + COL - 1, 0); add(WI, 1, 0);
        begin_pass(1'b1, 16'd4);
        run(nj + ROW + 2, -1, -1, -1);
        check_plan("ws");

        // OS, k_len=3; first pop also checks lane/nibble mapping 0x87654321
        plan_clear();
        add(OE, 3, 1); add(OM, 2 * ROW, 0); add(OI, 1, 0);
        begin_pass(1'b0, 16'd3);
        run(nj + ROW + 2, -1, -1, -1);
        check_plan("os");
        for (int r = 0; r < ROW; r++)
            chk($sformatf("map L%0d", r), rdat[2+r][r*BW +: BW], r + 1);

        // WS, k_len=4 with L0 empty in cycles 11 and 12 of EXEC
        plan_clear();
        add(WL, COL, 1); add(WI, 1, 0); add(WE, 1, 1); add(WI, 2, 0); add(WE, 3, 1);
        add(WI, ROW + COL - 1, 0); add(WI, 1, 0);
        begin_pass(1'b1, 16'd4);
        run(nj + ROW + 2, 11, 12, -1);
        check_plan("stall");
        chk("stall rd11", rrd[11], 0);
        chk("stall rd12", rrd[12], 0);
        chk("stall done_at", nj, 31);

        // OS, k_len=0, start pulsed again while busy
        plan_clear();
        add(OM, 2 * ROW, 0); add(OI, 1, 0);
        begin_pass(1'b0, 16'd0);
        run(nj + ROW + 2, -1, -1, 5);
        check_plan("k0");

        // Reset in the middle of a WS execute phase
        begin_pass(1'b1, 16'd4);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst inst", array_inst_w, 0);
        chk("midrst data", array_in_w, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst rd", l0.l0_rd, 0);
        for (int k = 0; k < 2 * ROW + COL; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postrst inst c%0d", k), array_inst_w, 0);
            chk($sformatf("postrst data c%0d", k), array_in_w, 0);
            chk($sformatf("postrst done c%0d", k), done, 0);
            chk($sformatf("postrst busy c%0d", k), busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
